tank_bullet_ctrl: RTL

TANK_BULLET_CTRL -- requirements
Module: tank_bullet_ctrl

---
 rtl/tank_pkg.sv | 29 ++
 rtl/bullet_slot.sv | 87 ++++++++
 rtl/tank_bullet_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared direction type, key codes and screen geometry for the tank controller
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h58;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Signed working width so a step past the top/left edge goes negative instead of wrapping.
  typedef logic signed [10:0] coord_t;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t hi);
    if (v < 0) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// rtl/bullet_slot.sv - one bullet: spawn, per-tick flight, off-screen retire and pixel hit test
module bullet_slot #(
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 4,
  parameter int BULLET_STEP = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           tick_i,
  input  logic           spawn_i,
  input  logic [9:0]     spawn_x_i,
  input  logic [9:0]     spawn_y_i,
  input  tank_pkg::dir_t spawn_dir_i,
  input  logic [9:0]     draw_x_i,
  input  logic [9:0]     draw_y_i,
  output logic           active_o,
  output logic           hit_o
);
  import tank_pkg::*;

  localparam coord_t X_MAX = coord_t'(SCREEN_W - BULLET_W);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - BULLET_H);
  localparam coord_t STEP  = coord_t'(BULLET_STEP);

  logic       active_q, active_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  dir_t       dir_q, dir_d;
  coord_t     nx, ny;
  logic       leaving;

  always_comb begin
    nx = $signed({1'b0, x_q});
    ny = $signed({1'b0, y_q});
    case (dir_q)
      DIR_UP:    ny = ny - STEP;
      DIR_DOWN:  ny = ny + STEP;
      DIR_LEFT:  nx = nx - STEP;
      DIR_RIGHT: nx = nx + STEP;
    endcase
    leaving = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);

    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    // A fresh spawn parks at the muzzle for its spawn tick; flight starts next tick.
    if (tick_i) begin
      if (spawn_i) begin
        active_d = 1'b1;
        x_d      = spawn_x_i;
        y_d      = spawn_y_i;
        dir_d    = spawn_dir_i;
      end else if (active_q) begin
        if (leaving) begin
          active_d = 1'b0;
        end else begin
          x_d = 10'(nx);
          y_d = 10'(ny);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_UP;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
    end
  end

  assign active_o = active_q;
  assign hit_o    = active_q
                 && ({1'b0, draw_x_i} >= {1'b0, x_q})
                 && ({1'b0, draw_x_i} <= ({1'b0, x_q} + 11'(BULLET_W - 1)))
                 && ({1'b0, draw_y_i} >= {1'b0, y_q})
                 && ({1'b0, draw_y_i} <= ({1'b0, y_q} + 11'(BULLET_H - 1)));

endmodule

// File: rtl/tank_bullet_ctrl.sv
// rtl/tank_bullet_ctrl.sv - tank movement, firing with cooldown, and bullet slot array, stepped once per frame
module tank_bullet_ctrl #(
  parameter int         NUM_BULLETS = 4,
  parameter int         X_START     = 500,
  parameter int         Y_START     = 240,
  parameter int         TANK_W      = 32,
  parameter int         TANK_H      = 32,
  parameter int         BULLET_W    = 4,
  parameter int         BULLET_H    = 4,
  parameter int         TANK_STEP   = 1,
  parameter int         BULLET_STEP = 4,
  parameter int         COOLDOWN    = 15,
  parameter int         SCREEN_W    = tank_pkg::SCREEN_W,
  parameter int         SCREEN_H    = tank_pkg::SCREEN_H,
  parameter logic [7:0] KEY_UP      = tank_pkg::KEY_UP,
  parameter logic [7:0] KEY_DOWN    = tank_pkg::KEY_DOWN,
  parameter logic [7:0] KEY_LEFT    = tank_pkg::KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT   = tank_pkg::KEY_RIGHT,
  parameter logic [7:0] KEY_FIRE    = tank_pkg::KEY_FIRE
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [7:0]             keycode,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   is_tank,
  output logic                   is_bullet,
  output logic [9:0]             tank_x,
  output logic [9:0]             tank_y,
  output tank_pkg::dir_t         tank_dir,
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic                   fire_pulse
);
  import tank_pkg::*;

  localparam int     CD_W       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam coord_t TANK_X_MAX = coord_t'(SCREEN_W - TANK_W);
  localparam coord_t TANK_Y_MAX = coord_t'(SCREEN_H - TANK_H);
  localparam coord_t TSTEP      = coord_t'(TANK_STEP);
  localparam logic [9:0] MUZ_DX    = 10'((TANK_W - BULLET_W) / 2);
  localparam logic [9:0] MUZ_DY    = 10'((TANK_H - BULLET_H) / 2);
  localparam logic [9:0] MUZ_RIGHT = 10'(TANK_W - BULLET_W);
  localparam logic [9:0] MUZ_DOWN  = 10'(TANK_H - BULLET_H);

  logic             frame_q;
  logic             tick_q, tick_d;
  logic [9:0]       tank_x_q, tank_x_d, tank_y_q, tank_y_d;
  dir_t             dir_q, dir_d, dir_mv;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             fire_pulse_q;
  coord_t           tx_mv, ty_mv;
  logic [9:0]       spawn_x, spawn_y;
  logic             fire_req, free_found, fire;
  logic [NUM_BULLETS-1:0] slot_active, slot_hit, spawn_vec;

  assign tick_d = frame_clk & ~frame_q;

  always_comb begin
    tx_mv  = $signed({1'b0, tank_x_q});
    ty_mv  = $signed({1'b0, tank_y_q});
    dir_mv = dir_q;
    if (keycode == KEY_UP) begin
      dir_mv = DIR_UP;
      ty_mv  = ty_mv - TSTEP;
    end else if (keycode == KEY_DOWN) begin
      dir_mv = DIR_DOWN;
      ty_mv  = ty_mv + TSTEP;
    end else if (keycode == KEY_LEFT) begin
      dir_mv = DIR_LEFT;
      tx_mv  = tx_mv - TSTEP;
    end else if (keycode == KEY_RIGHT) begin
      dir_mv = DIR_RIGHT;
      tx_mv  = tx_mv + TSTEP;
    end

    tank_x_d = tank_x_q;
    tank_y_d = tank_y_q;
    dir_d    = dir_q;
    if (tick_q) begin
      tank_x_d = 10'(clamp_coord(tx_mv, TANK_X_MAX));
      tank_y_d = 10'(clamp_coord(ty_mv, TANK_Y_MAX));
      dir_d    = dir_mv;
    end
  end

  // Muzzle is taken from the position and facing held before this tick's move.
  always_comb begin
    spawn_x = tank_x_q + MUZ_DX;
    spawn_y = tank_y_q;
    case (dir_q)
      DIR_UP: begin
        spawn_x = tank_x_q + MUZ_DX;
        spawn_y = tank_y_q;
      end
      DIR_DOWN: begin
        spawn_x = tank_x_q + MUZ_DX;
        spawn_y = tank_y_q + MUZ_DOWN;
      end
      DIR_LEFT: begin
        spawn_x = tank_x_q;
        spawn_y = tank_y_q + MUZ_DY;
      end
      DIR_RIGHT: begin
        spawn_x = tank_x_q + MUZ_RIGHT;
        spawn_y = tank_y_q + MUZ_DY;
      end
    endcase
  end

  // A slot retiring this tick still reads active, so it cannot be refilled until the next tick.
  always_comb begin
    fire_req   = tick_q && (keycode == KEY_FIRE) && (cd_q == '0);
    free_found = 1'b0;
    spawn_vec  = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_active[i] && !free_found) begin
        free_found   = 1'b1;
        spawn_vec[i] = fire_req;
      end
    end
    fire = fire_req && free_found;

    cd_d = cd_q;
    if (fire) begin
      cd_d = CD_W'(COOLDOWN);
    end else if (tick_q && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q      <= 1'b1;
      tick_q       <= 1'b0;
      tank_x_q     <= 10'(X_START);
      tank_y_q     <= 10'(Y_START);
      dir_q        <= DIR_UP;
      cd_q         <= '0;
      fire_pulse_q <= 1'b0;
    end else begin
      frame_q      <= frame_clk;
      tick_q       <= tick_d;
      tank_x_q     <= tank_x_d;
      tank_y_q     <= tank_y_d;
      dir_q        <= dir_d;
      cd_q         <= cd_d;
      fire_pulse_q <= fire;
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .BULLET_W   (BULLET_W),
      .BULLET_H   (BULLET_H),
      .BULLET_STEP(BULLET_STEP),
      .SCREEN_W   (SCREEN_W),
      .SCREEN_H   (SCREEN_H)
    ) u_slot (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick_i     (tick_q),
      .spawn_i    (spawn_vec[i]),
      .spawn_x_i  (spawn_x),
      .spawn_y_i  (spawn_y),
      .spawn_dir_i(dir_q),
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .active_o   (slot_active[i]),
      .hit_o      (slot_hit[i])
    );
  end

  assign is_tank = ({1'b0, DrawX} >= {1'b0, tank_x_q})
                && ({1'b0, DrawX} <= ({1'b0, tank_x_q} + 11'(TANK_W - 1)))
                && ({1'b0, DrawY} >= {1'b0, tank_y_q})
                && ({1'b0, DrawY} <= ({1'b0, tank_y_q} + 11'(TANK_H - 1)));

  assign is_bullet     = |slot_hit;
  assign tank_x        = tank_x_q;
  assign tank_y        = tank_y_q;
  assign tank_dir      = dir_q;
  assign bullet_active = slot_active;
  assign fire_pulse    = fire_pulse_q;

endmodule
